switch_send_queue: RTL

- Per-core send-side FIFO between a MatCore/VecCore switch send port and one `Switch` input slot.
- Accepts vector sends from the core in one cycle and replays them to the `Switch` with its ready/ok handshake, in order.
- The core is no longer stalled while the `Switch` arbitrates or while the destination core is not yet receiving.
- One instance per core slot in the multi-core top level.

---
 rtl/switch_send_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/switch_send_queue.sv
// Send-side FIFO between a core's switch send port and one Switch input slot.
// The core enqueues in one cycle and the queue replays entries to the Switch in strict order.
module switch_send_queue #(
   parameter int WIDTH          = 16,
   parameter int CORE_SIZE      = 8,
   parameter int DEPTH          = 4,
   localparam int CORE_ADDR_SIZE = $clog2(CORE_SIZE),
   localparam int CNT_SIZE       = $clog2(DEPTH + 1)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            core_send_ready,
   input  logic [CORE_ADDR_SIZE-1:0]       core_send_core_idx,
   input  logic [WIDTH-1:0][31:0]          core_send_data,
   output logic                            core_send_ok,
   output logic                            switch_send_ready,
   output logic [CORE_ADDR_SIZE-1:0]       switch_send_core_idx,
   output logic [WIDTH-1:0][31:0]          switch_send_data,
   input  logic                            switch_send_ok,
   output logic [CNT_SIZE-1:0]             count,
   output logic                            full,
   output logic                            empty,
   output logic [15:0]                     tx_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]          head_q, head_d;
   logic [PTR_W-1:0]          tail_q, tail_d;
   logic [CNT_SIZE-1:0]       count_q, count_d;
   logic [15:0]               tx_count_q, tx_count_d;
   logic [CORE_ADDR_SIZE-1:0] idx_mem_q  [DEPTH];
   logic [WIDTH-1:0][31:0]    data_mem_q [DEPTH];
   logic                      push, pop;

   assign full  = (count_q == CNT_SIZE'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign tx_count = tx_count_q;

   // No full-bypass: a pop in the same cycle does not make room for the push.
   assign push = core_send_ready && !full && !reset;
   assign pop  = switch_send_ok && !empty;

   assign core_send_ok         = push;
   assign switch_send_ready    = !empty;
   assign switch_send_core_idx = empty ? '0 : idx_mem_q[head_q];
   assign switch_send_data     = empty ? '0 : data_mem_q[head_q];

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      tx_count_d = tx_count_q;
      if (pop) begin
         head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
         if (tx_count_q != 16'hFFFF) begin
            tx_count_d = tx_count_q + 16'd1;
         end
      end
      if (push) begin
         tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         tx_count_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         tx_count_q <= tx_count_d;
      end
   end

   // Storage needs no reset: outputs are forced to zero whenever the queue is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         idx_mem_q[tail_q]  <= core_send_core_idx;
         data_mem_q[tail_q] <= core_send_data;
      end
   end

endmodule
